// File: rtl/square_pkg.sv
// rtl/square_pkg.sv - shared width default and incremental next-square helper
package square_pkg;

  localparam int SQ_W_DEFAULT = 4;

  // (x+1)^2 = x^2 + 2x + 1; callers cast the result down to their own 2W bits
  function automatic logic [63:0] sq_next(input logic [63:0] sq, input logic [63:0] x);
    return sq + (x << 1) + 64'd1;
  endfunction

endpackage

// File: rtl/square_check.sv
// rtl/square_check.sv - combinational check that a supplied square matches x*x
module square_check
  import square_pkg::*;
#(
  parameter int W = SQ_W_DEFAULT
) (
  input  logic [W-1:0]   i_x,
  input  logic [2*W-1:0] i_x_square,
  output logic           o_mismatch
);

  logic [2*W-1:0] w_prod;

  assign w_prod     = (2*W)'(i_x) * (2*W)'(i_x);
  assign o_mismatch = (w_prod != i_x_square);

endmodule

// File: rtl/square.sv
// rtl/square.sv - one-cycle incremental (x+1)^2 stage; SQUARE_CHECK_EN adds the x*x consistency flag
module square
  import square_pkg::*;
#(
  parameter int W = SQ_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   x_,
  input  logic [2*W-1:0] x_square,
  output logic           out_valid,
  output logic [W-1:0]   x_inc,
  output logic [2*W-1:0] x_inc_square,
  output logic           sq_err
);

  logic           r_out_valid;
  logic [W-1:0]   r_x_inc;
  logic [2*W-1:0] r_x_inc_square;
  logic [2*W-1:0] w_next_sq;

  // Supplied square is trusted as-is; no multiply on the datapath
  assign w_next_sq = (2*W)'(sq_next(64'(x_square), 64'(x_)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid    <= 1'b0;
      r_x_inc        <= '0;
      r_x_inc_square <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_x_inc        <= x_ + W'(1);
        r_x_inc_square <= w_next_sq;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign x_inc        = r_x_inc;
  assign x_inc_square = r_x_inc_square;

`ifdef SQUARE_CHECK_EN
  logic w_mismatch;
  logic r_sq_err;

  square_check #(.W(W)) u_check (
    .i_x        (x_),
    .i_x_square (x_square),
    .o_mismatch (w_mismatch)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sq_err <= 1'b0;
    end else if (in_valid) begin
      r_sq_err <= w_mismatch;
    end
  end

  assign sq_err = r_sq_err;
`else
  assign sq_err = 1'b0;
`endif

endmodule

// File: tb/tb_square.sv
// tb/tb_square.sv - directed self-checking bench for square
module tb_square;
  import square_pkg::*;

  localparam int W = SQ_W_DEFAULT;

`ifdef SQUARE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   x_;
  logic [2*W-1:0] x_square;
  logic           out_valid;
  logic [W-1:0]   x_inc;
  logic [2*W-1:0] x_inc_square;
  logic           sq_err;

  int checks = 0;
  int errors = 0;

  square #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .x_           (x_),
    .x_square     (x_square),
    .out_valid    (out_valid),
    .x_inc        (x_inc),
    .x_inc_square (x_inc_square),
    .sq_err       (sq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input int xi, input int xs, input logic se);
    chk({tag, ".out_valid"}, 16'(out_valid), 16'(ov));
    chk({tag, ".x_inc"}, 16'(x_inc), 16'(xi));
    chk({tag, ".x_inc_square"}, 16'(x_inc_square), 16'(xs));
    chk({tag, ".sq_err"}, 16'(sq_err), 16'(se));
  endtask

  task automatic step(input logic v, input int x, input int sq);
    @(negedge clk);
    in_valid = v;
    x_       = W'(x);
    x_square = (2*W)'(sq);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    x_ = '0;
    x_square = '0;

    step(1, 9, 81);
    chk_all("pre", 1, 10, 100, 0);

    // Asynchronous clear checked mid-cycle, away from any clock edge
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    x_ = 4'd11;
    x_square = 8'd3;
    #2;
    chk_all("reset_async", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("reset_hold", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;

    step(1, 0, 0); chk_all("seed0", 1, 1, 1, 0);
    step(1, 1, 1); chk_all("seed1", 1, 2, 4, 0);
    step(1, 2, 4); chk_all("seed2", 1, 3, 9, 0);
    step(1, 3, 9); chk_all("seed3", 1, 4, 16, 0);

    // Feedback chain 3 -> 15, then wrap to (0,0); valid never drops
    step(1, 3, 9);
    for (int k = 4; k <= 16; k++) begin
      chk_all($sformatf("chain%0d", k), 1, k % 16, (k % 16) * (k % 16), 0);
      if (k < 16) step(1, int'(x_inc), int'(x_inc_square));
    end

    step(1, 15, 225); chk_all("wrap", 1, 0, 0, 0);

    step(1, 5, 24); chk_all("bad", 1, 6, 35, CHK);
    step(1, 5, 25); chk_all("good", 1, 6, 36, 0);

    for (int h = 0; h < 3; h++) begin
      step(0, 13, 7);
      chk_all($sformatf("hold%0d", h), 0, 6, 36, 0);
    end

    step(1, 3, 9);
    step(1, int'(x_inc), int'(x_inc_square));
    chk_all("mid_pre", 1, 5, 25, 0);
    @(negedge clk);
    rst = 1'b0;
    x_ = x_inc;
    x_square = x_inc_square;
    #1;
    chk_all("mid_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    x_ = 4'd7;
    x_square = 8'd49;
    @(posedge clk);
    #1;
    chk_all("post_reset", 1, 8, 64, 0);

    step(0, 0, 0);
    chk_all("post_idle", 0, 8, 64, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
